// File: rtl/div_operand_norm_pkg.sv
// Shared definitions for the Goldschmidt divider front end and the divider itself.
package div_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHIFT_W = 4;

  typedef logic [SHIFT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } state_e;

  // Reciprocal seeds in Q1.15 for the midpoints of the four d_out[14:13] bins.
  localparam logic [WIDTH-1:0] IA0_C = 16'h71C7;  // 1/1.125
  localparam logic [WIDTH-1:0] IA1_C = 16'h5D17;  // 1/1.375
  localparam logic [WIDTH-1:0] IA2_C = 16'h4EC5;  // 1/1.625
  localparam logic [WIDTH-1:0] IA3_C = 16'h4444;  // 1/1.875

endpackage

// File: rtl/div_operand_norm_if.sv
// Operand handshake and normalised-result bus between upstream, this stage and the divider.
interface div_operand_norm_if;
  import div_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     n_in;
  logic [WIDTH-1:0]     d_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     n_out;
  logic [WIDTH-1:0]     d_out;
  logic [SHIFT_W-1:0]   shift_out;
  logic                 div_zero;
  logic [WIDTH-1:0]     ia0;
  logic [WIDTH-1:0]     ia1;
  logic [WIDTH-1:0]     ia2;
  logic [WIDTH-1:0]     ia3;

  // Upstream / divider side of the bus.
  modport master (
    output in_valid, n_in, d_in, out_ready,
    input  in_ready, out_valid, n_out, d_out, shift_out, div_zero, ia0, ia1, ia2, ia3
  );

  // Normalisation stage side of the bus.
  modport slave (
    input  in_valid, n_in, d_in, out_ready,
    output in_ready, out_valid, n_out, d_out, shift_out, div_zero, ia0, ia1, ia2, ia3
  );

endinterface

// File: rtl/div_operand_norm.sv
// Divisor normaliser: shifts D left one bit per cycle until bit 15 is set, counting shifts,
// and flags D = 0 so the divider is never started on it.
module div_operand_norm #(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  div_operand_norm_if.slave  bus
);
  import div_pkg::*;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_n, w_n_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  cnt_t             r_cnt, w_cnt_nxt;
  logic             r_zero, w_zero_nxt;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  // Next-state logic: capture in IDLE, one shift per NORM cycle, hold in DONE until taken.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_zero_nxt  = r_zero;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_n_nxt     = bus.n_in;
          w_d_nxt     = bus.d_in;
          w_cnt_nxt   = '0;
          w_zero_nxt  = 1'b0;
          w_state_nxt = StNorm;
        end
      end
      StNorm: begin
        if (r_d == '0) begin
          w_zero_nxt  = 1'b1;
          w_state_nxt = StDone;
        end else if (r_d[WIDTH-1]) begin
          w_state_nxt = StDone;
        end else begin
          // Leading one not yet at the MSB, so at most 15 shifts: cnt cannot wrap.
          w_d_nxt   = r_d << 1;
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Handshake flags decode from state only, so neither depends on the opposite valid/ready.
  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);

  assign bus.n_out     = r_n;
  assign bus.d_out     = r_d;
  assign bus.shift_out = r_cnt;
  assign bus.div_zero  = r_zero;

  assign bus.ia0 = IA0_C;
  assign bus.ia1 = IA1_C;
  assign bus.ia2 = IA2_C;
  assign bus.ia3 = IA3_C;

endmodule

// File: tb/tb_div_operand_norm.sv
// Directed bench for div_operand_norm: latency, normalisation, zero divisor, backpressure, reset.
module tb_div_operand_norm;

  logic clk;
  logic reset;

  int n_vec;
  int n_fail;

  div_operand_norm_if u_if ();

  div_operand_norm u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single accept edge.
  task automatic start_op(input logic [15:0] n, input logic [15:0] d);
    check("in_ready_before_accept", {31'd0, u_if.in_ready}, 32'd1);
    u_if.in_valid = 1'b1;
    u_if.n_in     = n;
    u_if.d_in     = d;
    tick();
    u_if.in_valid = 1'b0;
    check("in_ready_after_accept", {31'd0, u_if.in_ready}, 32'd0);
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_valid(input string tag, input int exp_lat);
    int cycles;
    cycles = 0;
    while (!u_if.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check(tag, cycles, exp_lat);
  endtask

  task automatic check_result(input logic [15:0] n, input logic [15:0] d,
                              input logic [3:0] s, input logic z);
    check("n_out", {16'd0, u_if.n_out}, {16'd0, n});
    check("d_out", {16'd0, u_if.d_out}, {16'd0, d});
    check("shift_out", {28'd0, u_if.shift_out}, {28'd0, s});
    check("div_zero", {31'd0, u_if.div_zero}, {31'd0, z});
  endtask

  task automatic take_result();
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    check("out_valid_after_take", {31'd0, u_if.out_valid}, 32'd0);
    check("in_ready_after_take", {31'd0, u_if.in_ready}, 32'd1);
  endtask

  initial begin
    logic seen_valid;
    n_vec          = 0;
    n_fail         = 0;
    reset          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.n_in      = '0;
    u_if.d_in      = '0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    check_result(16'd0, 16'd0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();

    // Already normalised divisor.
    start_op(16'd100, 16'h8000);
    wait_valid("lat_d8000", 1);
    check_result(16'd100, 16'h8000, 4'd0, 1'b0);
    take_result();

    // D = 3: fourteen shifts, seeds checked here.
    start_op(16'h1234, 16'h0003);
    wait_valid("lat_d0003", 15);
    check_result(16'h1234, 16'hC000, 4'd14, 1'b0);
    check("ia0", {16'd0, u_if.ia0}, 32'h71C7);
    check("ia1", {16'd0, u_if.ia1}, 32'h5D17);
    check("ia2", {16'd0, u_if.ia2}, 32'h4EC5);
    check("ia3", {16'd0, u_if.ia3}, 32'h4444);
    take_result();

    // Maximum shift count.
    start_op(16'hFFFF, 16'h0001);
    wait_valid("lat_d0001", 16);
    check_result(16'hFFFF, 16'h8000, 4'd15, 1'b0);
    take_result();

    // Divide by zero.
    start_op(16'h0005, 16'h0000);
    wait_valid("lat_d0000", 1);
    check_result(16'h0005, 16'h0000, 4'd0, 1'b1);
    take_result();

    // Zero flag must clear on the next capture.
    start_op(16'h0003, 16'h4000);
    wait_valid("lat_d4000", 2);
    check_result(16'h0003, 16'h8000, 4'd1, 1'b0);
    take_result();

    // Backpressure: hold DONE for five cycles and try to inject a new pair.
    start_op(16'h00AB, 16'h0100);
    wait_valid("lat_d0100", 8);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        u_if.in_valid = 1'b1;
        u_if.n_in     = 16'h5555;
        u_if.d_in     = 16'h0002;
      end
      tick();
      u_if.in_valid = 1'b0;
      check("stall_out_valid", {31'd0, u_if.out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, u_if.in_ready}, 32'd0);
      check_result(16'h00AB, 16'h8000, 4'd7, 1'b0);
    end
    take_result();
    check_result(16'h00AB, 16'h8000, 4'd7, 1'b0);

    // Reset mid-NORM abandons the operation.
    start_op(16'h0007, 16'h0010);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    check_result(16'd0, 16'd0, 4'd0, 1'b0);
    tick();
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (u_if.out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_emit", {31'd0, seen_valid}, 32'd0);

    // Next operation after the aborted one behaves normally.
    start_op(16'h0007, 16'h0010);
    wait_valid("lat_d0010", 12);
    check_result(16'h0007, 16'h8000, 4'd11, 1'b0);
    take_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
